vending_machine: RTL and testbench
==================================

Name: vending_machine

Overview:
- Coin-operated vending controller: accumulates nickel/dime deposits and asserts `valid` for one cycle when accumulated credit reaches the item price.
- Moore FSM with registered state; `valid` is decoded from state only.
- Standalone example block; the only inputs are the coin strobes sampled every clock.

Parameters:
- PRICE, 20, item price in cents; must be a positive multiple of 5, max 60.
- NICKEL_VALUE, 5, credit added by `coin[0]`.
- DIME_VALUE, 10, credit added by `coin[1]`.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- coin  input  2  coin strobes, sampled every rising edge; bit0 = nickel, bit1 = dime; 2'b11 = nickel and dime together.
- valid  output  1  dispense pulse; high for exactly one cycle per completed purchase.

Behaviour:
- Reset is synchronous, active-high, one clock, single domain. While `reset` is high at a rising edge:
  - state goes to IDLE and credit to 0;
  - `valid` = 0 in the following cycle;
  - reset has priority over any coin input;
  - reset mid-accumulation discards all credit.
- States:
  - IDLE: credit 0.
  - ACCUM: 0 < credit < PRICE.
  - DISPENSE.
  - Credit register width is 7 bits; the implementation may encode credit steps as explicit states (S5, S10, S15 for the default price).
- Per rising edge, when not in reset and not in DISPENSE:
  - sum = credit + (coin[0] ? NICKEL_VALUE : 0) + (coin[1] ? DIME_VALUE : 0).
  - If sum >= PRICE: go to DISPENSE; credit cleared to 0. Overpayment is forfeited; no change is returned.
  - Else if sum > 0: go to or stay in ACCUM with credit = sum.
  - Else: state and credit unchanged.
- DISPENSE:
  - `valid` = 1 only while in this state.
  - The next edge unconditionally returns to IDLE with credit 0.
  - Coins presented on the edge that leaves DISPENSE are ignored, not credited.
- Latency: `valid` rises in the cycle after the edge that samples the price-completing coin.
- `coin` = 0 holds state indefinitely; there is no timeout.
- The longest purchase is PRICE/NICKEL_VALUE coin edges, then one DISPENSE cycle.
- `valid` is never high on two consecutive cycles.

Test Plan:
- Reset held for 1 edge, then `coin` = 2'b01 held constant:
  - `valid` = 0 for the first 3 post-reset cycles;
  - `valid` = 1 in the cycle after the 4th sampled nickel;
  - `valid` = 0 the next cycle;
  - `valid` pulses again 5 cycles later (the DISPENSE-exit coin is ignored).
- Dime, idle, dime (2'b10, 2'b00, 2'b10) -> `valid` = 1 one cycle after the second dime; credit back to 0.
- Three nickels then a dime (credit 25) -> `valid` pulse; next purchase still needs the full 20.
- `coin` = 2'b11 twice -> credit 15 after the first edge, `valid` after the second (30 >= 20).
- Two dimes, no more coins -> exactly one `valid` pulse, then IDLE held indefinitely.
- Reset at credit 15, then 2 dimes -> `valid` only after the second dime; the pre-reset credit is lost.

Source files
------------

// File: rtl/vending_machine.sv
// Coin-operated vending controller: sums nickel/dime strobes and pulses valid once the price is met.
// Latency: valid rises the cycle after the price-completing coin edge. No backpressure; coins are sampled every cycle.
module vending_machine #(
    parameter int unsigned PRICE        = 20,
    parameter int unsigned NICKEL_VALUE = 5,
    parameter int unsigned DIME_VALUE   = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] coin,
    output logic       valid
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCUM    = 2'd1,
        DISPENSE = 2'd2
    } state_e;

    localparam logic [7:0] PRICE_W  = 8'(PRICE);
    localparam logic [7:0] NICKEL_W = 8'(NICKEL_VALUE);
    localparam logic [7:0] DIME_W   = 8'(DIME_VALUE);

    state_e     state_q, state_d;
    logic [6:0] credit_q, credit_d;
    logic [7:0] sum;

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        // One bit wider than credit so credit plus both coins cannot wrap.
        sum = {1'b0, credit_q}
            + (coin[0] ? NICKEL_W : 8'd0)
            + (coin[1] ? DIME_W   : 8'd0);

        case (state_q)
            IDLE, ACCUM: begin
                if (sum >= PRICE_W) begin
                    state_d  = DISPENSE;
                    credit_d = 7'd0;
                end else if (sum != 8'd0) begin
                    state_d  = ACCUM;
                    credit_d = sum[6:0];
                end
            end
            DISPENSE: begin
                // Coins seen on the exit edge are dropped, not credited.
                state_d  = IDLE;
                credit_d = 7'd0;
            end
            default: begin
                state_d  = IDLE;
                credit_d = 7'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            credit_q <= 7'd0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
        end
    end

    assign valid = (state_q == DISPENSE);

endmodule

// File: tb/tb_vending_machine.sv
// Directed bench for vending_machine at default price 20: each step drives reset/coin,
// lets one rising edge sample them, then checks valid against a hand-computed value.
module tb_vending_machine;

    logic       clk;
    logic       reset;
    logic [1:0] coin;
    logic       valid;

    int n_checks;
    int n_fail;

    vending_machine #(
        .PRICE       (20),
        .NICKEL_VALUE(5),
        .DIME_VALUE  (10)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .coin (coin),
        .valid(valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: valid=%0b expected %0b at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive inputs shortly after an edge, wait for the next edge, sample 1 time unit later.
    task automatic step(input logic rst, input logic [1:0] c, input logic exp, input string tag);
        reset = rst;
        coin  = c;
        @(posedge clk);
        #1;
        check_eq(tag, valid, exp);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        coin     = 2'b00;
        @(negedge clk);

        // Reset, including reset winning over coins.
        step(1'b1, 2'b00, 1'b0, "reset_idle");
        step(1'b1, 2'b11, 1'b0, "reset_over_coin");

        // Constant nickels: pulse after 4th, exit edge nickel ignored, pulse again 5 cycles later.
        step(1'b0, 2'b01, 1'b0, "nick_1");
        step(1'b0, 2'b01, 1'b0, "nick_2");
        step(1'b0, 2'b01, 1'b0, "nick_3");
        step(1'b0, 2'b01, 1'b1, "nick_4_dispense");
        step(1'b0, 2'b01, 1'b0, "nick_exit_ignored");
        step(1'b0, 2'b01, 1'b0, "nick_6");
        step(1'b0, 2'b01, 1'b0, "nick_7");
        step(1'b0, 2'b01, 1'b0, "nick_8");
        step(1'b0, 2'b01, 1'b1, "nick_9_dispense");
        step(1'b0, 2'b00, 1'b0, "nick_exit");

        // Dime, idle, dime.
        step(1'b0, 2'b10, 1'b0, "dime_1");
        step(1'b0, 2'b00, 1'b0, "dime_hold");
        step(1'b0, 2'b10, 1'b1, "dime_2_dispense");
        step(1'b0, 2'b00, 1'b0, "dime_exit");

        // Overpay to 25; the next purchase still needs the full 20.
        step(1'b0, 2'b01, 1'b0, "over_n1");
        step(1'b0, 2'b01, 1'b0, "over_n2");
        step(1'b0, 2'b01, 1'b0, "over_n3");
        step(1'b0, 2'b10, 1'b1, "over_25_dispense");
        step(1'b0, 2'b00, 1'b0, "over_exit");
        step(1'b0, 2'b10, 1'b0, "after_over_10");
        step(1'b0, 2'b01, 1'b0, "after_over_15");
        step(1'b0, 2'b01, 1'b1, "after_over_20");
        step(1'b0, 2'b00, 1'b0, "after_over_exit");

        // Both coins together: 15, then 30.
        step(1'b0, 2'b11, 1'b0, "both_15");
        step(1'b0, 2'b11, 1'b1, "both_30_dispense");
        step(1'b0, 2'b00, 1'b0, "both_exit");

        // Two dimes then idle held for a long time.
        step(1'b0, 2'b10, 1'b0, "idle_d1");
        step(1'b0, 2'b10, 1'b1, "idle_d2_dispense");
        for (int i = 0; i < 20; i++) step(1'b0, 2'b00, 1'b0, $sformatf("idle_hold_%0d", i));

        // Dime on the exit edge must not be credited: 5 + 10 stays below price.
        step(1'b0, 2'b10, 1'b0, "exitd_d1");
        step(1'b0, 2'b10, 1'b1, "exitd_d2_dispense");
        step(1'b0, 2'b10, 1'b0, "exitd_dime_ignored");
        step(1'b0, 2'b01, 1'b0, "exitd_5");
        step(1'b0, 2'b10, 1'b0, "exitd_15");
        step(1'b0, 2'b01, 1'b1, "exitd_20_dispense");
        step(1'b0, 2'b00, 1'b0, "exitd_exit");

        // Reset at credit 15 discards it.
        step(1'b0, 2'b10, 1'b0, "rst15_d");
        step(1'b0, 2'b01, 1'b0, "rst15_n");
        step(1'b1, 2'b00, 1'b0, "rst15_reset");
        step(1'b0, 2'b10, 1'b0, "rst15_d1");
        step(1'b0, 2'b10, 1'b1, "rst15_d2_dispense");
        step(1'b0, 2'b00, 1'b0, "rst15_exit");

        // Reset beats a price-completing coin.
        step(1'b0, 2'b10, 1'b0, "rstc_d1");
        step(1'b1, 2'b10, 1'b0, "rstc_reset_with_dime");
        step(1'b0, 2'b10, 1'b0, "rstc_d2");
        step(1'b0, 2'b00, 1'b0, "rstc_hold");
        step(1'b0, 2'b10, 1'b1, "rstc_d3_dispense");
        step(1'b0, 2'b00, 1'b0, "rstc_exit");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
